// File: rtl/idli_sqi_m.sv
// SQI memory sequencer: CMD/ADDR/DUMMY/DATA frames of four nibbles,
// aligned to the external frame counter, with sequential-burst reuse.
module idli_sqi_m (
  input  logic        i_sqi_gck,
  input  logic        i_sqi_rst,
  input  logic [1:0]  i_sqi_ctr,
  input  logic        i_sqi_ctr_last_cycle,
  input  logic        i_sqi_req,
  input  logic        i_sqi_wr,
  input  logic [15:0] i_sqi_addr,
  input  logic [3:0]  i_sqi_wdata,
  input  logic [3:0]  i_sqi_sio_in,
  output logic [3:0]  o_sqi_sio_out,
  output logic        o_sqi_sio_oe,
  output logic        o_sqi_cs_n,
  output logic        o_sqi_busy,
  output logic [3:0]  o_sqi_rdata,
  output logic        o_sqi_rdata_vld
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA
  } state_t;

  state_t      state;
  logic        wr_q;
  logic [15:0] addr_q;
  logic [7:0]  cmd;

  always_ff @(posedge i_sqi_gck or posedge i_sqi_rst) begin
    if (i_sqi_rst) begin
      state  <= IDLE;
      wr_q   <= 1'b0;
      addr_q <= '0;
    end else if (i_sqi_ctr_last_cycle) begin
      case (state)
        IDLE: begin
          if (i_sqi_req) begin
            state  <= CMD;
            wr_q   <= i_sqi_wr;
            addr_q <= i_sqi_addr;
          end
        end
        CMD:   state <= ADDR;
        ADDR:  state <= wr_q ? DATA : DUMMY;
        DUMMY: state <= DATA;
        DATA: begin
          // Burst continues only in the same direction; the device
          // advances its own address pointer.
          if (!(i_sqi_req && (i_sqi_wr == wr_q)))
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd = wr_q ? 8'h02 : 8'h03;

  always_comb begin
    o_sqi_sio_out   = 4'h0;
    o_sqi_sio_oe    = 1'b0;
    o_sqi_rdata_vld = 1'b0;
    case (state)
      CMD: begin
        o_sqi_sio_oe = 1'b1;
        case (i_sqi_ctr)
          2'd0:    o_sqi_sio_out = cmd[7:4];
          2'd1:    o_sqi_sio_out = cmd[3:0];
          default: o_sqi_sio_out = 4'h0;
        endcase
      end
      ADDR: begin
        o_sqi_sio_oe = 1'b1;
        case (i_sqi_ctr)
          2'd0:    o_sqi_sio_out = addr_q[15:12];
          2'd1:    o_sqi_sio_out = addr_q[11:8];
          2'd2:    o_sqi_sio_out = addr_q[7:4];
          default: o_sqi_sio_out = addr_q[3:0];
        endcase
      end
      DATA: begin
        if (wr_q) begin
          o_sqi_sio_oe  = 1'b1;
          o_sqi_sio_out = i_sqi_wdata;
        end else begin
          o_sqi_rdata_vld = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign o_sqi_cs_n  = (state == IDLE);
  assign o_sqi_busy  = (state != IDLE);
  assign o_sqi_rdata = i_sqi_sio_in;

endmodule

// File: tb/tb_idli_sqi_m.sv
// Directed bench for idli_sqi_m: read, write, alignment,
// burst and mid-transfer reset scenarios.
module tb_idli_sqi_m;

  logic        clk;
  logic        rst;
  logic [1:0]  ctr;
  logic        last;
  logic        req;
  logic        wr;
  logic [15:0] addr;
  logic [3:0]  wdata;
  logic [3:0]  sio_in;
  logic [3:0]  sio_out;
  logic        oe;
  logic        cs_n;
  logic        busy;
  logic [3:0]  rdata;
  logic        vld;

  int n_pass;
  int n_total;

  idli_sqi_m dut (
    .i_sqi_gck            (clk),
    .i_sqi_rst            (rst),
    .i_sqi_ctr            (ctr),
    .i_sqi_ctr_last_cycle (last),
    .i_sqi_req            (req),
    .i_sqi_wr             (wr),
    .i_sqi_addr           (addr),
    .i_sqi_wdata          (wdata),
    .i_sqi_sio_in         (sio_in),
    .o_sqi_sio_out        (sio_out),
    .o_sqi_sio_oe         (oe),
    .o_sqi_cs_n           (cs_n),
    .o_sqi_busy           (busy),
    .o_sqi_rdata          (rdata),
    .o_sqi_rdata_vld      (vld)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Frame counter advances just after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    ctr  = ctr + 2'd1;
    last = (ctr == 2'd3);
  endtask

  task automatic wait_ctr(input logic [1:0] t);
    while (ctr != t) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_total++;
    if (cs_n !== 1'b1 || oe !== 1'b0 || sio_out !== 4'h0 ||
        busy !== 1'b0 || vld !== 1'b0)
      $display("FAIL reset_state: cs_n=%b oe=%b out=%h busy=%b vld=%b want 1 0 0 0 0",
               cs_n, oe, sio_out, busy, vld);
    else n_pass++;
    tick();
    tick();
    rst = 1'b0;
    tick();
    #1;
    n_total++;
    if (cs_n !== 1'b1 || busy !== 1'b0)
      $display("FAIL idle_after_reset: cs_n=%b busy=%b want 1 0", cs_n, busy);
    else n_pass++;
  endtask

  task automatic test_read();
    logic [63:0] outs;
    logic [15:0] oem;
    logic [15:0] vldm;
    outs = 64'h0300_A5C3_0000_0000;
    oem  = 16'hFF00;
    vldm = 16'h000F;
    wait_ctr(2'd3);
    req = 1'b1; wr = 1'b0; addr = 16'hA5C3;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 0) req = 1'b0;
      sio_in = 4'(i + 3);
      #1;
      n_total++;
      if (cs_n !== 1'b0 || busy !== 1'b1 || oe !== oem[15-i] ||
          vld !== vldm[15-i] ||
          (oem[15-i] && sio_out !== outs[63-4*i -: 4]) ||
          (vldm[15-i] && rdata !== 4'(i + 3)))
        $display("FAIL read_cyc%0d: cs_n=%b oe=%b out=%h vld=%b rd=%h want 0 %b %h %b %h",
                 i, cs_n, oe, sio_out, vld, rdata,
                 oem[15-i], outs[63-4*i -: 4], vldm[15-i], 4'(i + 3));
      else n_pass++;
    end
    tick();
    #1;
    n_total++;
    if (cs_n !== 1'b1 || busy !== 1'b0 || vld !== 1'b0)
      $display("FAIL read_end: cs_n=%b busy=%b vld=%b want 1 0 0", cs_n, busy, vld);
    else n_pass++;
  endtask

  task automatic test_write();
    logic [47:0] outs;
    int          nbusy;
    outs  = 48'h0200_0010_1234;
    nbusy = 0;
    wait_ctr(2'd3);
    req = 1'b1; wr = 1'b1; addr = 16'h0010;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 0) req = 1'b0;
      wdata = (i >= 8) ? 4'(i - 7) : 4'hF;
      #1;
      if (busy === 1'b1) nbusy++;
      if (i < 12) begin
        n_total++;
        if (cs_n !== 1'b0 || oe !== 1'b1 || vld !== 1'b0 ||
            sio_out !== outs[47-4*i -: 4])
          $display("FAIL write_cyc%0d: cs_n=%b oe=%b out=%h vld=%b want 0 1 %h 0",
                   i, cs_n, oe, sio_out, vld, outs[47-4*i -: 4]);
        else n_pass++;
      end
    end
    n_total++;
    if (nbusy != 12)
      $display("FAIL write_busy_len: got %0d want 12", nbusy);
    else n_pass++;
    wr = 1'b0;
  endtask

  task automatic test_align();
    wait_ctr(2'd1);
    req = 1'b1; wr = 1'b0; addr = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++;
      if (cs_n !== 1'b1 || busy !== 1'b0)
        $display("FAIL align_wait_ctr%0d: cs_n=%b busy=%b want 1 0", ctr, cs_n, busy);
      else n_pass++;
      tick();
    end
    req = 1'b0;
    #1;
    n_total++;
    if (ctr !== 2'd0 || cs_n !== 1'b0 || oe !== 1'b1 || sio_out !== 4'h0)
      $display("FAIL align_cmd_start: ctr=%0d cs_n=%b oe=%b out=%h want 0 0 1 0",
               ctr, cs_n, oe, sio_out);
    else n_pass++;
    tick();
    #1;
    n_total++;
    if (sio_out !== 4'h3)
      $display("FAIL align_cmd_nib1: out=%h want 3", sio_out);
    else n_pass++;
    for (int i = 0; i < 15; i++) tick();
    #1;
    n_total++;
    if (cs_n !== 1'b1 || busy !== 1'b0)
      $display("FAIL align_end: cs_n=%b busy=%b want 1 0", cs_n, busy);
    else n_pass++;
  endtask

  task automatic test_burst();
    int nvld;
    int noe;
    int noe_data;
    nvld = 0; noe = 0; noe_data = 0;
    wait_ctr(2'd3);
    req = 1'b1; wr = 1'b0; addr = 16'h4000;
    for (int i = 0; i < 24; i++) begin
      tick();
      sio_in = 4'(i);
      #1;
      if (vld === 1'b1 && i >= 12) nvld++;
      if (oe === 1'b1) noe++;
      if (oe === 1'b1 && i >= 12) noe_data++;
      if (i == 23) wr = 1'b1;
    end
    n_total++;
    if (nvld != 12)
      $display("FAIL burst_vld_count: got %0d want 12", nvld);
    else n_pass++;
    n_total++;
    if (noe != 8 || noe_data != 0)
      $display("FAIL burst_no_recmd: oe cycles %0d/%0d want 8/0", noe, noe_data);
    else n_pass++;
    tick();
    req = 1'b0;
    wr  = 1'b0;
    #1;
    n_total++;
    if (cs_n !== 1'b1 || busy !== 1'b0 || vld !== 1'b0)
      $display("FAIL burst_dir_flip: cs_n=%b busy=%b vld=%b want 1 0 0", cs_n, busy, vld);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int ncs;
    ncs = 0;
    wait_ctr(2'd3);
    req = 1'b1; wr = 1'b0; addr = 16'hBEEF;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 0) req = 1'b0;
    end
    #1;
    n_total++;
    if (ctr !== 2'd2 || oe !== 1'b1 || sio_out !== 4'hE)
      $display("FAIL rstmid_pre: ctr=%0d oe=%b out=%h want 2 1 e", ctr, oe, sio_out);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if (cs_n !== 1'b1 || oe !== 1'b0 || busy !== 1'b0 || sio_out !== 4'h0)
      $display("FAIL rstmid_async: cs_n=%b oe=%b busy=%b out=%h want 1 0 0 0",
               cs_n, oe, busy, sio_out);
    else n_pass++;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      #1;
      if (cs_n !== 1'b1) ncs++;
    end
    n_total++;
    if (ncs != 0)
      $display("FAIL rstmid_no_frames: cs_n low %0d cycles want 0", ncs);
    else n_pass++;
    wait_ctr(2'd3);
    req = 1'b1; wr = 1'b1; addr = 16'h0000;
    tick();
    req = 1'b0;
    tick();
    #1;
    n_total++;
    if (cs_n !== 1'b0 || oe !== 1'b1 || sio_out !== 4'h2)
      $display("FAIL rstmid_recover: cs_n=%b oe=%b out=%h want 0 1 2", cs_n, oe, sio_out);
    else n_pass++;
    for (int i = 0; i < 11; i++) tick();
    #1;
    n_total++;
    if (cs_n !== 1'b1 || busy !== 1'b0)
      $display("FAIL rstmid_end: cs_n=%b busy=%b want 1 0", cs_n, busy);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    ctr     = 2'd0;
    last    = 1'b0;
    req     = 1'b0;
    wr      = 1'b0;
    addr    = 16'h0;
    wdata   = 4'h0;
    sio_in  = 4'h0;
    test_reset();
    test_read();
    test_write();
    test_align();
    test_burst();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
